// File: rtl/sprite_line_engine.sv
// Sprite line engine: per-scanline sprite evaluator and graphics row fetcher.
//
// A start pulse latches the requested line. The engine then streams every OAM
// entry through a one-cycle read pipeline and keeps up to MAX_PER_LINE hits in
// a shadow table. It fetches one graphics row word per kept sprite, and finally
// copies the shadow table to the published slot outputs with a done pulse.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, line       begin evaluation of 'line' (ignored while busy)
//   oam_addr/rdata    OAM read port, data valid one cycle after address
//   gfx_addr/rdata    sprite graphics read port, data valid one cycle after address
//   busy, done        engine active / one-cycle publish strobe
//   overflow          more hits than slots on the last published line
//   slot_*            published slot table (packed, slot i at [i*W +: W])
//
// Optional feature macro: SPRITE_HFLIP_EN
//   defined   -> OAM bit 29 reverses the 2-bit pixel order of the fetched row
//   undefined -> OAM bit 29 is ignored

module sprite_line_engine #(
    parameter int NUM_SPRITES  = 64,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_H     = 16,
    parameter int GFX_AW       = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [9:0]                     line,
    output logic [$clog2(NUM_SPRITES)-1:0] oam_addr,
    input  logic [31:0]                    oam_rdata,
    output logic [GFX_AW-1:0]              gfx_addr,
    input  logic [31:0]                    gfx_rdata,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [MAX_PER_LINE-1:0]        slot_valid,
    output logic [MAX_PER_LINE*10-1:0]     slot_x,
    output logic [MAX_PER_LINE-1:0]        slot_palette,
    output logic [MAX_PER_LINE*32-1:0]     slot_pixels
);

    localparam int OAM_AW = $clog2(NUM_SPRITES);
    localparam int SCAN_W = OAM_AW + 1;
    // Headroom so the fetch counter can reach hits+1 without wrapping.
    localparam int CNT_W  = $clog2(MAX_PER_LINE + 2);
    localparam int ROW_W  = $clog2(SPRITE_H);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, PUBLISH} state_t;

    state_t              state;
    logic [9:0]          line_q;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [CNT_W-1:0]    hit_cnt;
    logic [CNT_W-1:0]    fetch_cnt;
    logic                shadow_overflow;

    logic [9:0]          sh_x    [MAX_PER_LINE];
    logic                sh_pal  [MAX_PER_LINE];
    logic [GFX_AW-1:0]   sh_addr [MAX_PER_LINE];
    logic [31:0]         sh_pix  [MAX_PER_LINE];

`ifdef SPRITE_HFLIP_EN
    logic                sh_hflip [MAX_PER_LINE];

    function automatic logic [31:0] reverse_pixels(input logic [31:0] raw);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[2*i +: 2] = raw[2*(15-i) +: 2];
        end
        return r;
    endfunction
`else
    logic                unused_hflip;
    assign unused_hflip = oam_rdata[29];
`endif

    // Evaluation of the OAM word returned for the entry issued last cycle.
    // diff is 11 bits so a y above line cannot wrap into a small distance.
    logic [10:0]         diff;
    logic                ev_valid;
    logic                ev_hit;
    logic                room;
    logic                take;
    logic [ROW_W-1:0]    ev_row;
    logic [31:0]         ev_addr_full;
    logic [GFX_AW-1:0]   ev_addr;
    logic [CNT_W-1:0]    hits_total;
    logic [CNT_W-1:0]    cap_idx;
    logic [CNT_W-1:0]    next_idx;

    assign diff     = {1'b0, line_q} - {1'b0, oam_rdata[19:10]};
    assign ev_valid = (state == SCAN) && (scan_cnt != '0);
    assign ev_hit   = oam_rdata[31] && (line_q >= oam_rdata[19:10]) &&
                      (diff < 11'(SPRITE_H));
    assign room     = hit_cnt < CNT_W'(MAX_PER_LINE);
    assign take     = ev_valid && ev_hit && room;

    // SPRITE_H is a power of two, so SPRITE_H-1-row is the bitwise inverse
    // and tile*SPRITE_H+row is a plain concatenation.
    assign ev_row       = oam_rdata[30] ? ~diff[ROW_W-1:0] : diff[ROW_W-1:0];
    assign ev_addr_full = 32'({oam_rdata[27:20], ev_row});
    assign ev_addr      = ev_addr_full[GFX_AW-1:0];

    // Hit count including the word being evaluated this cycle; needed on the
    // last scan cycle to choose between FETCH and PUBLISH.
    assign hits_total = hit_cnt + CNT_W'(take);
    assign cap_idx    = fetch_cnt - CNT_W'(1);
    assign next_idx   = fetch_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            line_q          <= '0;
            scan_cnt        <= '0;
            hit_cnt         <= '0;
            fetch_cnt       <= '0;
            shadow_overflow <= 1'b0;
            oam_addr        <= '0;
            gfx_addr        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            slot_valid      <= '0;
            slot_x          <= '0;
            slot_palette    <= '0;
            slot_pixels     <= '0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                sh_x[i]    <= '0;
                sh_pal[i]  <= 1'b0;
                sh_addr[i] <= '0;
                sh_pix[i]  <= '0;
`ifdef SPRITE_HFLIP_EN
                sh_hflip[i] <= 1'b0;
`endif
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        line_q          <= line;
                        scan_cnt        <= '0;
                        hit_cnt         <= '0;
                        fetch_cnt       <= '0;
                        shadow_overflow <= 1'b0;
                        oam_addr        <= '0;
                        busy            <= 1'b1;
                        state           <= SCAN;
                        for (int i = 0; i < MAX_PER_LINE; i++) begin
                            sh_x[i]    <= '0;
                            sh_pal[i]  <= 1'b0;
                            sh_addr[i] <= '0;
                            sh_pix[i]  <= '0;
`ifdef SPRITE_HFLIP_EN
                            sh_hflip[i] <= 1'b0;
`endif
                        end
                    end
                end

                SCAN: begin
                    if (take) begin
                        for (int i = 0; i < MAX_PER_LINE; i++) begin
                            if (CNT_W'(i) == hit_cnt) begin
                                sh_x[i]    <= oam_rdata[9:0];
                                sh_pal[i]  <= oam_rdata[28];
                                sh_addr[i] <= ev_addr;
`ifdef SPRITE_HFLIP_EN
                                sh_hflip[i] <= oam_rdata[29];
`endif
                            end
                        end
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end
                    if (ev_valid && ev_hit && !room) begin
                        shadow_overflow <= 1'b1;
                    end
                    if (scan_cnt < SCAN_W'(NUM_SPRITES - 1)) begin
                        oam_addr <= oam_addr + OAM_AW'(1);
                    end
                    if (scan_cnt == SCAN_W'(NUM_SPRITES)) begin
                        if (hits_total == '0) begin
                            state <= PUBLISH;
                        end else begin
                            // Slot 0 may be written this very cycle.
                            gfx_addr <= (hit_cnt == '0) ? ev_addr : sh_addr[0];
                            state    <= FETCH;
                        end
                    end
                    scan_cnt <= scan_cnt + SCAN_W'(1);
                end

                FETCH: begin
                    // Data for the address issued last cycle lands in the
                    // previous slot; the next slot's address goes out now.
                    for (int i = 0; i < MAX_PER_LINE; i++) begin
                        if ((fetch_cnt != '0) && (CNT_W'(i) == cap_idx)) begin
`ifdef SPRITE_HFLIP_EN
                            sh_pix[i] <= sh_hflip[i] ? reverse_pixels(gfx_rdata)
                                                     : gfx_rdata;
`else
                            sh_pix[i] <= gfx_rdata;
`endif
                        end
                        if ((next_idx < hit_cnt) && (CNT_W'(i) == next_idx)) begin
                            gfx_addr <= sh_addr[i];
                        end
                    end
                    if (fetch_cnt == hit_cnt) begin
                        state <= PUBLISH;
                    end
                    fetch_cnt <= next_idx;
                end

                PUBLISH: begin
                    for (int i = 0; i < MAX_PER_LINE; i++) begin
                        slot_valid[i]          <= CNT_W'(i) < hit_cnt;
                        slot_x[i*10 +: 10]     <= (CNT_W'(i) < hit_cnt) ? sh_x[i] : 10'd0;
                        slot_palette[i]        <= (CNT_W'(i) < hit_cnt) && sh_pal[i];
                        slot_pixels[i*32 +: 32] <= (CNT_W'(i) < hit_cnt) ? sh_pix[i] : 32'd0;
                    end
                    overflow <= shadow_overflow;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Testbench for sprite_line_engine: directed scenarios plus randomized OAM
// contents, checked against a behavioural per-line model of sprite selection.

module tb_sprite_line_engine;

    localparam int NS  = 64;
    localparam int MPL = 8;
    localparam int SH  = 16;
    localparam int GAW = 11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [9:0]           line;
    logic [5:0]           oam_addr;
    logic [31:0]          oam_rdata;
    logic [GAW-1:0]       gfx_addr;
    logic [31:0]          gfx_rdata;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [MPL-1:0]       slot_valid;
    logic [MPL*10-1:0]    slot_x;
    logic [MPL-1:0]       slot_palette;
    logic [MPL*32-1:0]    slot_pixels;

    sprite_line_engine #(
        .NUM_SPRITES (NS),
        .MAX_PER_LINE(MPL),
        .SPRITE_H    (SH),
        .GFX_AW      (GAW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .line        (line),
        .oam_addr    (oam_addr),
        .oam_rdata   (oam_rdata),
        .gfx_addr    (gfx_addr),
        .gfx_rdata   (gfx_rdata),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .slot_valid  (slot_valid),
        .slot_x      (slot_x),
        .slot_palette(slot_palette),
        .slot_pixels (slot_pixels)
    );

    always #5 clk = ~clk;

    logic [31:0] oam_mem [NS];
    logic [31:0] gfx_mem [1 << GAW];

    // Synchronous memories: data valid the cycle after the address.
    always @(posedge clk) begin
        oam_rdata <= oam_mem[oam_addr];
        gfx_rdata <= gfx_mem[gfx_addr];
    end

    int checks = 0;
    int errors = 0;

    logic        exp_valid [MPL];
    logic [9:0]  exp_x     [MPL];
    logic        exp_pal   [MPL];
    logic [31:0] exp_pix   [MPL];
    int          exp_addr  [MPL];
    int          exp_n;
    logic        exp_ovf;
    int          exp_lat;
    int          meas_lat;
    bit          done_seen;

    function automatic logic [31:0] mk(input logic en, input logic vf, input logic hf,
                                       input logic pal, input logic [7:0] tile,
                                       input logic [9:0] y, input logic [9:0] x);
        return {en, vf, hf, pal, tile, y, x};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearOam();
        for (int k = 0; k < NS; k++) oam_mem[k] = 32'd0;
    endtask

    // Reference: walk OAM in index order, keep the first MPL covering sprites.
    task automatic modelLine(input int ln);
        int y, row, addr;
        logic [31:0] w, raw, pix;
        exp_n   = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < MPL; i++) begin
            exp_valid[i] = 1'b0; exp_x[i] = '0; exp_pal[i] = 1'b0;
            exp_pix[i] = '0; exp_addr[i] = 0;
        end
        for (int k = 0; k < NS; k++) begin
            w = oam_mem[k];
            y = int'(w[19:10]);
            if (w[31] && ln >= y && (ln - y) < SH) begin
                row = ln - y;
                if (w[30]) row = SH - 1 - row;
                addr = (int'(w[27:20]) * SH + row) % (1 << GAW);
                if (exp_n < MPL) begin
                    raw = gfx_mem[addr];
                    pix = raw;
`ifdef SPRITE_HFLIP_EN
                    if (w[29]) for (int j = 0; j < 16; j++) pix[2*j +: 2] = raw[2*(15-j) +: 2];
`endif
                    exp_valid[exp_n] = 1'b1;
                    exp_x[exp_n]     = w[9:0];
                    exp_pal[exp_n]   = w[28];
                    exp_pix[exp_n]   = pix;
                    exp_addr[exp_n]  = addr;
                    exp_n++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        exp_lat = 1 + (NS + 1) + ((exp_n > 0) ? exp_n + 1 : 0) + 1;
    endtask

    // Pulse start for line ln and wait (bounded) for done. Optionally pulse a
    // second start mid-scan with a different line, which must be ignored.
    task automatic applyStimulus(input logic [9:0] ln, input bit glitch);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; line = ln;
        @(posedge clk); #1;
        start = 1'b0; line = 10'($urandom);
        cyc = 1;
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            if (glitch && cyc == 5) begin
                start = 1'b1; line = ln ^ 10'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done) done_seen = 1'b1;
        end
        meas_lat = done_seen ? cyc : -1;
    endtask

    task automatic checkAll(input string tag);
        logic [MPL-1:0] vexp;
        checkOutput($sformatf("%s_done_seen", tag), 64'(done_seen), 64'(1));
        checkOutput($sformatf("%s_latency", tag), 64'(meas_lat), 64'(exp_lat));
        checkOutput($sformatf("%s_busy_at_done", tag), 64'(busy), 64'(0));
        checkOutput($sformatf("%s_overflow", tag), 64'(overflow), 64'(exp_ovf));
        for (int i = 0; i < MPL; i++) begin
            vexp[i] = exp_valid[i];
            checkOutput($sformatf("%s_valid%0d", tag, i), 64'(slot_valid[i]), 64'(exp_valid[i]));
            checkOutput($sformatf("%s_x%0d", tag, i), 64'(slot_x[i*10 +: 10]), 64'(exp_x[i]));
            checkOutput($sformatf("%s_pal%0d", tag, i), 64'(slot_palette[i]), 64'(exp_pal[i]));
            checkOutput($sformatf("%s_pix%0d", tag, i), 64'(slot_pixels[i*32 +: 32]), 64'(exp_pix[i]));
        end
        if (exp_n > 0) checkOutput($sformatf("%s_gfx_hold", tag), 64'(gfx_addr), 64'(exp_addr[exp_n-1]));
        checkOutput($sformatf("%s_oam_hold", tag), 64'(oam_addr), 64'(NS - 1));
        @(posedge clk); #1;
        checkOutput($sformatf("%s_done_pulse", tag), 64'(done), 64'(0));
        checkOutput($sformatf("%s_valid_stable", tag), 64'(slot_valid), 64'(vexp));
    endtask

    initial begin
        int dens, y, ln, ndone;
        reset = 1'b1; start = 1'b0; line = '0;
        clearOam();
        for (int a = 0; a < (1 << GAW); a++) gfx_mem[a] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_valid", 64'(slot_valid), 64'(0));
        checkOutput("rst_oam_addr", 64'(oam_addr), 64'(0));
        checkOutput("rst_gfx_addr", 64'(gfx_addr), 64'(0));
        reset = 1'b0;

        // One sprite at OAM[3]
        $display("[TB] single sprite");
        oam_mem[3] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 10'd100, 10'd200);
        modelLine(107);
        applyStimulus(10'd107, 1'b0);
        checkOutput("one_gfx_addr", 64'(gfx_addr), 64'(39));
        checkOutput("one_x", 64'(slot_x[9:0]), 64'(200));
        checkOutput("one_pix", 64'(slot_pixels[31:0]), 64'(gfx_mem[39]));
        checkAll("one");

        // Vertical flip
        $display("[TB] vflip");
        oam_mem[3] = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 10'd100, 10'd200);
        modelLine(100);
        applyStimulus(10'd100, 1'b0);
        checkOutput("vflip_gfx_addr", 64'(gfx_addr), 64'(47));
        checkAll("vflip");

        // Overflow: ten sprites on one line, with an ignored start mid-scan
        $display("[TB] overflow");
        clearOam();
        for (int k = 0; k < 10; k++)
            oam_mem[k] = mk(1'b1, 1'b0, 1'b0, k[0], 8'(k + 5), 10'd50, 10'(k * 3 + 1));
        modelLine(50);
        applyStimulus(10'd50, 1'b1);
        checkOutput("ovf_flag", 64'(overflow), 64'(1));
        checkOutput("ovf_valid_all", 64'(slot_valid), 64'(8'hFF));
        checkAll("ovf");

        // Zero hits clears overflow
        $display("[TB] zero hits");
        modelLine(300);
        applyStimulus(10'd300, 1'b0);
        checkOutput("zero_latency_const", 64'(meas_lat), 64'(67));
        checkAll("zero");

        // Reset mid-scan after a published overflow line
        $display("[TB] reset mid-scan");
        modelLine(50);
        applyStimulus(10'd50, 1'b0);
        checkAll("ovf2");
        @(posedge clk); #1;
        start = 1'b1; line = 10'd50;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_done", 64'(done), 64'(0));
        checkOutput("midrst_valid", 64'(slot_valid), 64'(0));
        checkOutput("midrst_overflow", 64'(overflow), 64'(0));
        checkOutput("midrst_pixels0", 64'(slot_pixels[63:0]), 64'(0));
        ndone = 0;
        repeat (80) begin @(posedge clk); #1; if (done) ndone++; end
        checkOutput("midrst_no_done", 64'(ndone), 64'(0));
        oam_mem[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 10'd0, 10'd77);
        modelLine(5);
        applyStimulus(10'd5, 1'b0);
        checkAll("after_rst");

        // Edges around y=50; a disabled sprite at the same y never hits
        $display("[TB] edges");
        clearOam();
        oam_mem[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 10'd50, 10'd10);
        oam_mem[1] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 10'd50, 10'd20);
        modelLine(49); applyStimulus(10'd49, 1'b0); checkAll("edge49");
        modelLine(66); applyStimulus(10'd66, 1'b0); checkAll("edge66");
        modelLine(65); applyStimulus(10'd65, 1'b0);
        checkOutput("edge65_gfx_addr", 64'(gfx_addr), 64'(4 * 16 + 15));
        checkAll("edge65");

        // Horizontal flip
        $display("[TB] hflip");
        clearOam();
        oam_mem[3] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 10'd100, 10'd200);
        gfx_mem[39] = 32'h0000_0001;
        modelLine(107);
        applyStimulus(10'd107, 1'b0);
`ifdef SPRITE_HFLIP_EN
        checkOutput("hflip_pix", 64'(slot_pixels[31:0]), 64'(32'h4000_0000));
`else
        checkOutput("hflip_pix", 64'(slot_pixels[31:0]), 64'(32'h0000_0001));
`endif
        checkAll("hflip");

        // Randomized OAM at varying densities, including y just above line
        for (int r = 0; r < 8; r++) begin
            dens = (r % 4 == 0) ? 3 : (r % 4 == 1) ? 10 : (r % 4 == 2) ? 30 : 100;
            ln = $urandom_range(0, 1023);
            for (int k = 0; k < NS; k++) begin
                y = (ln + 1024 - $urandom_range(0, 24)) % 1024;
                oam_mem[k] = mk(1'($urandom_range(0, 99) < dens), 1'($urandom), 1'($urandom),
                                1'($urandom), 8'($urandom), 10'(y), 10'($urandom));
            end
            modelLine(ln);
            applyStimulus(10'(ln), r[0]);
            checkAll($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
